sensor_lectura: RTL and testbench

Sensor acquisition front end and data producer for the alarm controller FSM. Every PERIODO cycles it samples the sensor bus and waits until the sampled value has held for ESTABLE consecutive cycles. It then latches the value, computes the danger flag, and pulses Dato_listo for one cycle. Dato_listo and Peligro drive the controller's read/decide/alert sequence directly.

---
 rtl/sensor_lectura_if.sv | 21 ++
 rtl/sensor_lectura.sv | 145 ++++++++++++++
 tb/tb_sensor_lectura.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_lectura_if.sv
// Sensor front-end bus: enable and raw sensor lines in, accepted reading and status out.
interface sensor_lectura_if #(
  parameter int N_SENSORES = 4
) ();
  logic                  Habilitar;
  logic [N_SENSORES-1:0] Sensores;
  logic                  Dato_listo;
  logic                  Peligro;
  logic [N_SENSORES-1:0] Datos;
  logic                  Error_lectura;
  logic [1:0]            Estado;

  modport master (
    output Habilitar, Sensores,
    input  Dato_listo, Peligro, Datos, Error_lectura, Estado
  );
  modport slave (
    input  Habilitar, Sensores,
    output Dato_listo, Peligro, Datos, Error_lectura, Estado
  );
endinterface

// File: rtl/sensor_lectura.sv
// Periodic sensor sampler: waits PERIODO cycles, then accepts a reading once it has
// held for ESTABLE consecutive synchronized samples, flagging danger by popcount.
module sensor_lectura #(
  parameter int N_SENSORES   = 4,
  parameter int PERIODO      = 1000,
  parameter int ESTABLE      = 3,
  parameter int MAX_INTENTOS = 12,
  parameter int UMBRAL       = 2
) (
  input  logic              clk,
  input  logic              rst,
  sensor_lectura_if.slave   bus
);
  localparam int CW = $clog2(PERIODO);
  localparam int MW = $clog2(ESTABLE + 1);
  localparam int IW = $clog2(MAX_INTENTOS + 1);
  localparam int PW = $clog2(N_SENSORES + 1);

  typedef enum logic [1:0] {ESPERA = 2'b00, MUESTREO = 2'b01, LISTO = 2'b10} estado_t;

  estado_t               r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [MW-1:0]         r_match, w_match_nx, w_match_upd;
  logic [IW-1:0]         r_int, w_int_nx;
  logic [N_SENSORES-1:0] r_prev, w_prev_nx;
  logic [N_SENSORES-1:0] r_s1, r_s2;
  logic [N_SENSORES-1:0] r_datos;
  logic                  r_peligro, r_err;
  logic                  w_accept, w_timeout;
  logic [PW-1:0]         w_pop;

  // Two-flop synchronizer; r_s2 is the only view of the sensors used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.Sensores;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_SENSORES; i++) w_pop = w_pop + PW'(r_s2[i]);
  end

  // r_int==0 inside MUESTREO marks the first window cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_match_nx  = r_match;
    w_int_nx    = r_int;
    w_prev_nx   = r_prev;
    w_match_upd = '0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ESPERA: begin
        if (bus.Habilitar) begin
          if (r_cnt == CW'(PERIODO - 1)) begin
            w_state_nx = MUESTREO;
            w_cnt_nx   = '0;
            w_int_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        end
      end
      MUESTREO: begin
        if (!bus.Habilitar) begin
          w_state_nx = ESPERA;
          w_cnt_nx   = '0;
          w_int_nx   = '0;
          w_match_nx = '0;
        end else if (r_int == '0) begin
          w_prev_nx  = r_s2;
          w_match_nx = MW'(1);
          w_int_nx   = IW'(1);
        end else begin
          w_match_upd = (r_s2 == r_prev) ? r_match + MW'(1) : MW'(1);
          w_prev_nx   = r_s2;
          w_match_nx  = w_match_upd;
          w_int_nx    = r_int + IW'(1);
          if (w_match_upd == MW'(ESTABLE)) begin
            w_accept   = 1'b1;
            w_state_nx = LISTO;
            w_int_nx   = '0;
          end else if (r_int == IW'(MAX_INTENTOS)) begin
            w_timeout  = 1'b1;
            w_state_nx = ESPERA;
            w_cnt_nx   = '0;
            w_int_nx   = '0;
          end
        end
      end
      LISTO: begin
        w_state_nx = ESPERA;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = ESPERA;
        w_cnt_nx   = '0;
        w_int_nx   = '0;
        w_match_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ESPERA;
      r_cnt   <= '0;
      r_match <= '0;
      r_int   <= '0;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_match <= w_match_nx;
      r_int   <= w_int_nx;
      r_prev  <= w_prev_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_datos   <= '0;
      r_peligro <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_datos   <= r_s2;
      r_peligro <= (w_pop >= PW'(UMBRAL));
      r_err     <= 1'b0;
    end else if (w_timeout) begin
      r_err     <= 1'b1;
    end
  end

  assign bus.Dato_listo    = (r_state == LISTO);
  assign bus.Estado        = r_state;
  assign bus.Datos         = r_datos;
  assign bus.Peligro       = r_peligro;
  assign bus.Error_lectura = r_err;
endmodule

// File: tb/tb_sensor_lectura.sv
// Self-checking bench for sensor_lectura against a cycle-level behavioural model.
module tb_sensor_lectura;
  localparam int N = 4, PER = 8, EST = 3, MAXI = 12, UMB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // behavioural model state; phase 0=wait, 1=sampling, 2=ready
  int           m_ph, m_cnt, m_tries, m_run_len;
  logic [N-1:0] m_run_val, m_datos, sq0, sq1;
  logic         m_pel, m_err;

  sensor_lectura_if #(.N_SENSORES(N)) bus ();

  sensor_lectura #(
    .N_SENSORES(N), .PERIODO(PER), .ESTABLE(EST), .MAX_INTENTOS(MAXI), .UMBRAL(UMB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] exp_vec();
    return {m_ph == 2, m_pel, m_datos, m_err, 2'(m_ph)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.Dato_listo, bus.Peligro, bus.Datos, bus.Error_lectura, bus.Estado};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_tries = 0; m_run_len = 0;
    m_run_val = '0; m_datos = '0; sq0 = '0; sq1 = '0;
    m_pel = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    s = sq1; sq1 = sq0; sq0 = bus.Sensores;
    case (m_ph)
      0: if (bus.Habilitar) begin
           if (m_cnt == PER - 1) begin m_ph = 1; m_cnt = 0; m_tries = 0; end
           else m_cnt++;
         end
      1: if (!bus.Habilitar) begin
           m_ph = 0; m_cnt = 0;
         end else if (m_tries == 0) begin
           m_run_val = s; m_run_len = 1; m_tries = 1;
         end else begin
           if (s == m_run_val) m_run_len++;
           else begin m_run_val = s; m_run_len = 1; end
           if (m_run_len == EST) begin
             m_datos = s; m_pel = ($countones(s) >= UMB); m_err = 1'b0; m_ph = 2;
           end else if (m_tries == MAXI) begin
             m_err = 1'b1; m_ph = 0; m_cnt = 0;
           end
           m_tries++;
         end
      default: begin m_ph = 0; m_cnt = 0; end
    endcase
  endtask

  task automatic step(input logic hab, input logic [N-1:0] sens);
    bus.Habilitar = hab;
    bus.Sensores  = sens;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    bus.Habilitar = 1'b1;
    bus.Sensores  = 4'b0011;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== 9'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want %b", dut_vec(), 9'b0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, 4'b0011);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL basic_cycle%0d: got %b want %b", k, dut_vec(), exp_vec());
      end
      if (k == 11 || k == 23) begin
        total++;
        if ({bus.Dato_listo, bus.Datos, bus.Peligro, bus.Estado} !== {1'b1, 4'b0011, 1'b1, 2'b10}) begin
          bad++; $display("FAIL basic_pulse_c%0d: got dl=%b d=%b p=%b e=%b want dl=1 d=0011 p=1 e=10",
                          k, bus.Dato_listo, bus.Datos, bus.Peligro, bus.Estado);
        end
      end else begin
        total++;
        if (bus.Dato_listo !== 1'b0) begin
          bad++; $display("FAIL basic_nopulse_c%0d: got %b want 0", k, bus.Dato_listo);
        end
      end
    end
  endtask

  task automatic test_threshold();
    logic [N-1:0] pats [2] = '{4'b0100, 4'b1111};
    logic         pel  [2] = '{1'b0, 1'b1};
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 40; i++) begin
        step(1'b1, pats[p]);
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++; $display("FAIL thr_cycle: got %b want %b", dut_vec(), exp_vec());
        end
        if (m_ph == 2 && m_datos == pats[p]) break;
      end
      total++;
      if ({bus.Dato_listo, bus.Datos, bus.Peligro} !== {1'b1, pats[p], pel[p]}) begin
        bad++; $display("FAIL thr_read%0d: got dl=%b d=%b p=%b want dl=1 d=%b p=%b",
                        p, bus.Dato_listo, bus.Datos, bus.Peligro, pats[p], pel[p]);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 60 && !(m_ph == 0 && m_cnt == 6); i++) step(1'b1, 4'b0011);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0011);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 4'b0111);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL glitch_cycle%0d: got %b want %b", k, dut_vec(), exp_vec());
      end
      if (bus.Dato_listo === 1'b1) pulses++;
      if (k == 2) begin
        total++;
        if (bus.Estado !== 2'b01) begin
          bad++; $display("FAIL glitch_no_early_accept: got %b want 01", bus.Estado);
        end
      end
    end
    step(1'b1, 4'b0111);
    if (bus.Dato_listo === 1'b1) pulses++;
    total++;
    if (pulses != 1 || bus.Datos !== 4'b0111) begin
      bad++; $display("FAIL glitch_accept: got pulses=%0d d=%b want pulses=1 d=0111", pulses, bus.Datos);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, (i % 2) ? 4'b1111 : 4'b0000);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL tmo_cycle%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (bus.Dato_listo === 1'b1) pulses++;
      if (m_err) break;
    end
    total++;
    if ({bus.Error_lectura, bus.Datos} !== {1'b1, 4'b0111} || pulses != 0) begin
      bad++; $display("FAIL tmo_flag: got err=%b d=%b pulses=%0d want err=1 d=0111 pulses=0",
                      bus.Error_lectura, bus.Datos, pulses);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 4'b0101);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL tmo_recover_cycle: got %b want %b", dut_vec(), exp_vec());
      end
      if (m_ph == 2) break;
    end
    total++;
    if ({bus.Dato_listo, bus.Error_lectura, bus.Datos, bus.Peligro} !== {1'b1, 1'b0, 4'b0101, 1'b1}) begin
      bad++; $display("FAIL tmo_clear: got dl=%b err=%b d=%b p=%b want dl=1 err=0 d=0101 p=1",
                      bus.Dato_listo, bus.Error_lectura, bus.Datos, bus.Peligro);
    end
  endtask

  task automatic test_enable();
    int n;
    for (int i = 0; i < 40 && !(m_ph == 0 && m_cnt == 5); i++) step(1'b1, 4'b0101);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0101);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL en_hold_cycle%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    for (n = 0; n < 20; n++) if (bus.Estado === 2'b01) break; else step(1'b1, 4'b0101);
    total++;
    if (n != 3) begin
      bad++; $display("FAIL en_resume: got %0d cycles want 3", n);
    end
    step(1'b1, 4'b0101);
    step(1'b1, 4'b0101);
    step(1'b0, 4'b0101);
    total++;
    if ({bus.Estado, bus.Dato_listo, bus.Error_lectura} !== {2'b00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL en_abort: got e=%b dl=%b err=%b want e=00 dl=0 err=0",
                      bus.Estado, bus.Dato_listo, bus.Error_lectura);
    end
    for (n = 0; n < 20; n++) begin
      if (bus.Estado === 2'b01) break;
      step(1'b1, 4'b0101);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL en_restart_cycle: got %b want %b", dut_vec(), exp_vec());
      end
    end
    total++;
    if (n != 8) begin
      bad++; $display("FAIL en_abort_restart: got %0d cycles want 8", n);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v = 4'b0000;
    logic         h;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) v = 4'($urandom);
      h = ($urandom_range(0, 19) != 0);
      step(h, v);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_cycle%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_listo();
    for (int i = 0; i < 60 && m_ph != 2; i++) step(1'b1, 4'b1011);
    total++;
    if ({bus.Dato_listo, bus.Peligro} !== 2'b11) begin
      bad++; $display("FAIL rl_pre: got dl=%b p=%b want 11", bus.Dato_listo, bus.Peligro);
    end
    rst = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 9'b0) begin
      bad++; $display("FAIL rl_async_clear: got %b want %b", dut_vec(), 9'b0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 4'b1011);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rl_cycle%0d: got %b want %b", k, dut_vec(), exp_vec());
      end
      if (k == 11) begin
        total++;
        if ({bus.Dato_listo, bus.Datos} !== {1'b1, 4'b1011}) begin
          bad++; $display("FAIL rl_restart: got dl=%b d=%b want dl=1 d=1011", bus.Dato_listo, bus.Datos);
        end
      end
    end
  endtask

  initial begin
    bus.Habilitar = 1'b0;
    bus.Sensores  = '0;
    test_reset();
    test_threshold();
    test_glitch();
    test_timeout();
    test_enable();
    test_random();
    test_reset_listo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
